// File: rtl/dc_video_mode_encoder.sv
// Dreamcast video mode encoder.
// Counts lines per field, detects interlace from field parity, classifies the
// incoming timing, debounces it over several fields and publishes the 8-bit
// video-config byte {force_vga, mode_bits, out_res} with a change strobe.
module dc_video_mode_encoder #(
  parameter int STABLE_FIELDS  = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int L240_MIN       = 258,
  parameter int L240_MAX       = 268,
  parameter int L288_MIN       = 308,
  parameter int L288_MAX       = 318,
  parameter int L480P_MIN      = 520,
  parameter int L480P_MAX      = 530,
  parameter int L576P_MIN      = 620,
  parameter int L576P_MAX      = 630
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       line_strobe,
  input  logic       field_strobe,
  input  logic       field_parity,
  input  logic [1:0] out_res,
  input  logic       force_vga,
  output logic [7:0] config_byte,
  output logic       config_strobe,
  output logic       locked
);

  localparam int SW = $clog2(STABLE_FIELDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_N = SW'(STABLE_FIELDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [10:0] L240_LO = 11'(L240_MIN);
  localparam logic [10:0] L240_HI = 11'(L240_MAX);
  localparam logic [10:0] L288_LO = 11'(L288_MIN);
  localparam logic [10:0] L288_HI = 11'(L288_MAX);
  localparam logic [10:0] L480_LO = 11'(L480P_MIN);
  localparam logic [10:0] L480_HI = 11'(L480P_MAX);
  localparam logic [10:0] L576_LO = 11'(L576P_MIN);
  localparam logic [10:0] L576_HI = 11'(L576P_MAX);

  localparam logic [4:0] M480P = 5'h00;
  localparam logic [4:0] M288P = 5'h01;
  localparam logic [4:0] M576P = 5'h02;
  localparam logic [4:0] M240P = 5'h04;
  localparam logic [4:0] M480I = 5'h08;
  localparam logic [4:0] M576I = 5'h10;

  typedef enum logic [1:0] {NO_SIGNAL, MEASURE, LOCKED} state_t;

  state_t        state;
  logic [10:0]   line_cnt;
  logic          par_q;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stable_cnt;
  logic [4:0]    cand;
  logic          cand_vld;
  logic [4:0]    mode;

  logic          interlaced;
  logic          cls_vld;
  logic [4:0]    cls_mode;
  logic [SW-1:0] stable_inc;
  logic          tmo_hit;
  logic          meas_match;
  logic          commit;
  logic          lock_drop;
  logic [7:0]    byte_nxt;

  assign interlaced = field_parity != par_q;
  assign stable_inc = stable_cnt + SW'(1);
  assign tmo_hit    = (state != NO_SIGNAL) && !field_strobe && (tmo_cnt == TMO_LAST);
  assign meas_match = cand_vld && cls_vld && (cls_mode == cand);
  // STABLE_FIELDS >= 2 assumed: a commit always follows a matching candidate
  assign commit     = (state == MEASURE) && field_strobe && meas_match && (stable_inc == STABLE_N);
  assign lock_drop  = (state == LOCKED) && field_strobe && !(cls_vld && (cls_mode == mode));

  // Classify the field closing on this field_strobe (line_cnt holds its count)
  always_comb begin
    cls_vld  = 1'b1;
    cls_mode = M480P;
    if (line_cnt >= L240_LO && line_cnt <= L240_HI)      cls_mode = interlaced ? M480I : M240P;
    else if (line_cnt >= L288_LO && line_cnt <= L288_HI) cls_mode = interlaced ? M576I : M288P;
    else if (line_cnt >= L480_LO && line_cnt <= L480_HI) cls_mode = M480P;
    else if (line_cnt >= L576_LO && line_cnt <= L576_HI) cls_mode = M576P;
    else                                                 cls_vld  = 1'b0;
  end

  // Next config byte: loaded at commit, tracks host inputs while stably locked
  always_comb begin
    byte_nxt = config_byte;
    if (commit)
      byte_nxt = {force_vga, cand, out_res};
    else if (state == LOCKED && !lock_drop && !tmo_hit)
      byte_nxt = {force_vga, mode, out_res};
  end

  // Counters, mode FSM and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= NO_SIGNAL;
      line_cnt      <= '0;
      par_q         <= 1'b0;
      tmo_cnt       <= '0;
      stable_cnt    <= '0;
      cand          <= '0;
      cand_vld      <= 1'b0;
      mode          <= '0;
      locked        <= 1'b0;
      config_byte   <= '0;
      config_strobe <= 1'b0;
    end else begin
      // a line_strobe coincident with field_strobe is the first line of the new field
      if (field_strobe)
        line_cnt <= line_strobe ? 11'd1 : 11'd0;
      else if (line_strobe && line_cnt != 11'h7FF)
        line_cnt <= line_cnt + 11'd1;

      if (field_strobe)
        par_q <= field_parity;

      if (field_strobe || state == NO_SIGNAL || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);

      config_byte   <= byte_nxt;
      config_strobe <= byte_nxt != config_byte;

      case (state)
        NO_SIGNAL: begin
          // first field edge only primes parity and line count
          if (field_strobe) begin
            state      <= MEASURE;
            stable_cnt <= '0;
            cand_vld   <= 1'b0;
          end
        end
        MEASURE: begin
          if (tmo_hit) begin
            state      <= NO_SIGNAL;
            stable_cnt <= '0;
            cand_vld   <= 1'b0;
          end else if (field_strobe) begin
            if (!cls_vld) begin
              stable_cnt <= '0;
              cand_vld   <= 1'b0;
            end else if (meas_match) begin
              stable_cnt <= stable_inc;
              if (commit) begin
                state  <= LOCKED;
                locked <= 1'b1;
                mode   <= cand;
              end
            end else begin
              cand       <= cls_mode;
              cand_vld   <= 1'b1;
              stable_cnt <= SW'(1);
            end
          end
        end
        LOCKED: begin
          if (tmo_hit) begin
            state      <= NO_SIGNAL;
            locked     <= 1'b0;
            stable_cnt <= '0;
            cand_vld   <= 1'b0;
          end else if (lock_drop) begin
            state      <= MEASURE;
            locked     <= 1'b0;
            cand       <= cls_mode;
            cand_vld   <= cls_vld;
            stable_cnt <= cls_vld ? SW'(1) : '0;
          end
        end
        default: state <= NO_SIGNAL;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_video_mode_encoder.sv
// Directed bench for dc_video_mode_encoder: a table of fields with expected
// byte/locked/strobe-count after each, then hand sequences for host changes,
// timeout, re-commit without strobe and reset mid-measurement.
module tb_dc_video_mode_encoder;

  localparam int TMO = 3000;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       line_strobe = 1'b0;
  logic       field_strobe = 1'b0;
  logic       field_parity = 1'b0;
  logic [1:0] out_res = 2'd0;
  logic       force_vga = 1'b0;
  logic [7:0] config_byte;
  logic       config_strobe;
  logic       locked;

  int n_chk = 0;
  int n_fail = 0;
  int n_str = 0;

  typedef struct {
    int         lines;
    logic       par;
    logic [1:0] res;
    logic       fv;
    logic [7:0] exp_byte;
    logic       exp_lk;
    int         exp_str;
  } vec_t;

  vec_t vq[$];

  dc_video_mode_encoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetn(resetn), .line_strobe(line_strobe),
    .field_strobe(field_strobe), .field_parity(field_parity),
    .out_res(out_res), .force_vga(force_vga), .config_byte(config_byte),
    .config_strobe(config_strobe), .locked(locked)
  );

  always #5 clock = ~clock;

  // count config_strobe pulses (sampled at the edge ending the pulse cycle)
  always @(posedge clock) if (config_strobe === 1'b1) n_str++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      line_strobe  = 1'b0;
      field_strobe = 1'b0;
    end
  endtask

  // n lines then a field strobe; returns at the negedge after the strobe edge
  task automatic send_field(int n, logic par);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      line_strobe  = 1'b1;
      field_strobe = 1'b0;
    end
    @(negedge clock);
    line_strobe  = 1'b0;
    field_strobe = 1'b1;
    field_parity = par;
    @(negedge clock);
    field_strobe = 1'b0;
  endtask

  task automatic add(int l, logic p, logic [1:0] r, logic f, logic [7:0] b, logic k, int s);
    vec_t v;
    v.lines = l; v.par = p; v.res = r; v.fv = f;
    v.exp_byte = b; v.exp_lk = k; v.exp_str = s;
    vq.push_back(v);
  endtask

  initial begin
    // 240p: prime + 4 fields, window edges, invalid fields incl. saturation
    add(263, 0, 0, 0, 8'h00, 0, 0);
    add(263, 0, 0, 0, 8'h00, 0, 0);
    add(263, 0, 0, 0, 8'h00, 0, 0);
    add(263, 0, 0, 0, 8'h00, 0, 0);
    add(263, 0, 0, 0, 8'h10, 1, 1);
    add(258, 0, 0, 0, 8'h10, 1, 1);
    add(268, 0, 0, 0, 8'h10, 1, 1);
    add(400, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(2311, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(263, 0, 0, 0, 8'h10, 0, 1);
    add(269, 0, 0, 0, 8'h10, 0, 1);
    // 576i with toggling parity, host res=2 force_vga=1
    add(312, 1, 2, 1, 8'h10, 0, 1);
    add(312, 0, 2, 1, 8'h10, 0, 1);
    add(312, 1, 2, 1, 8'h10, 0, 1);
    add(312, 0, 2, 1, 8'hC2, 1, 2);
    // host back to 0 while locked (byte 0x40), then 480p, then 576p
    add(525, 0, 0, 0, 8'h40, 0, 3);
    add(525, 0, 0, 0, 8'h40, 0, 3);
    add(525, 0, 0, 0, 8'h40, 0, 3);
    add(525, 0, 0, 0, 8'h00, 1, 4);
    add(525, 0, 0, 0, 8'h00, 1, 4);
    add(625, 0, 0, 0, 8'h00, 0, 4);
    add(625, 0, 0, 0, 8'h00, 0, 4);
    add(625, 0, 0, 0, 8'h00, 0, 4);
    add(625, 0, 0, 0, 8'h08, 1, 5);

    // reset state
    idle(3);
    chk("reset_byte", config_byte, 8'h00);
    chk("reset_locked", locked, 1'b0);
    chk("reset_strobe", config_strobe, 1'b0);
    resetn = 1'b1;

    foreach (vq[i]) begin
      out_res   = vq[i].res;
      force_vga = vq[i].fv;
      send_field(vq[i].lines, vq[i].par);
      chk($sformatf("vec%0d_byte", i), config_byte, vq[i].exp_byte);
      chk($sformatf("vec%0d_locked", i), locked, vq[i].exp_lk);
      idle(1);
      chk($sformatf("vec%0d_strobes", i), n_str, vq[i].exp_str);
    end

    // host change while locked: appears next cycle with a strobe
    @(negedge clock); out_res = 2'd3;
    @(negedge clock);
    chk("host_locked_byte", config_byte, 8'h0B);
    chk("host_locked_strobe", config_strobe, 1'b1);
    out_res = 2'd0;
    idle(2);
    chk("host_back_byte", config_byte, 8'h08);
    chk("host_strobes", n_str, 7);

    // timeout: hold lock just short of the limit, drop after it
    send_field(625, 0);
    chk("pre_tmo_locked", locked, 1'b1);
    idle(TMO - 100);
    chk("tmo_near_locked", locked, 1'b1);
    idle(200);
    chk("tmo_locked", locked, 1'b0);
    chk("tmo_byte", config_byte, 8'h08);
    chk("tmo_strobes", n_str, 7);

    // host change while unlocked is ignored
    out_res = 2'd3; force_vga = 1'b1;
    idle(5);
    chk("host_unlocked_byte", config_byte, 8'h08);
    chk("host_unlocked_strobes", n_str, 7);

    // recovery from NO_SIGNAL: prime + 4 fields of 480p
    for (int i = 0; i < 5; i++) send_field(525, 0);
    idle(1);
    chk("recover_byte", config_byte, 8'h83);
    chk("recover_locked", locked, 1'b1);
    chk("recover_strobes", n_str, 8);

    // unlock then re-commit same byte: no strobe
    send_field(625, 0);
    chk("recommit_unlock", locked, 1'b0);
    for (int i = 0; i < 3; i++) send_field(525, 0);
    chk("recommit_3rd_locked", locked, 1'b0);
    send_field(525, 0);
    idle(1);
    chk("recommit_locked", locked, 1'b1);
    chk("recommit_byte", config_byte, 8'h83);
    chk("recommit_strobes", n_str, 8);

    // reset mid-measurement: aborts, no partial commit
    out_res = 2'd0; force_vga = 1'b0;
    resetn = 1'b0;
    idle(2);
    chk("rst2_byte", config_byte, 8'h00);
    chk("rst2_locked", locked, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) send_field(263, 0);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) send_field(263, 0);
    chk("rst_mid_locked", locked, 1'b0);
    chk("rst_mid_byte", config_byte, 8'h00);
    for (int i = 0; i < 2; i++) send_field(263, 0);
    idle(1);
    chk("rst_after_locked", locked, 1'b1);
    chk("rst_after_byte", config_byte, 8'h10);
    chk("rst_after_strobes", n_str, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
